// File: rtl/led_pkg.sv
// Shared mode encodings and default step period for the LED pattern generator.
package led_pkg;

  typedef logic [1:0] led_mode_t;

  localparam led_mode_t LED_MODE_ROR      = 2'd0;
  localparam led_mode_t LED_MODE_ROL      = 2'd1;
  localparam led_mode_t LED_MODE_PINGPONG = 2'd2;
  localparam led_mode_t LED_MODE_BLINK    = 2'd3;

  // One step per second from a 50 MHz board clock.
  localparam int LED_STEP_CYCLES = 50_000_000;

endpackage

// File: rtl/led_flow_ctrl_if.sv
// Control/status bundle between the LED pattern generator and its driver.
// The master drives mode/pause and observes the active-low LED word and step pulse.
interface led_flow_ctrl_if #(
  parameter int LED_NUM = 4
);
  import led_pkg::*;

  led_mode_t          mode;
  logic               pause;
  logic [LED_NUM-1:0] led;
  logic               step;

  modport master (output mode, output pause, input led, input step);
  modport slave  (input mode, input pause, output led, output step);

endinterface

// File: rtl/step_tick_gen.sv
// Step divider: tick is high combinationally in the last enabled cycle of each period.
// en low freezes the count; clr forces the count back to zero and masks nothing else.
module step_tick_gen
  import led_pkg::*;
#(
  parameter int STEP_CYCLES = LED_STEP_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int             CW   = $clog2(STEP_CYCLES);
  localparam logic [CW-1:0]  TERM = CW'(STEP_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == TERM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/led_flow_ctrl.sv
// Active-low LED pattern generator (rotate right/left, ping-pong, blink); led/step registered, 1-cycle latency.
// pause freezes both the divider and the pattern; a mode change restarts the pattern without a step pulse.
module led_flow_ctrl
  import led_pkg::*;
#(
  parameter int LED_NUM     = 4,
  parameter int STEP_CYCLES = LED_STEP_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst_n,
  led_flow_ctrl_if.slave           bus
);

  localparam int                  PW      = $clog2(LED_NUM);
  localparam logic [PW-1:0]       POS_MAX = PW'(LED_NUM - 1);
  localparam logic [LED_NUM-1:0]  LED_RST = {1'b0, {(LED_NUM-1){1'b1}}};

  logic [PW-1:0]      pos_q, pos_d;
  logic               dir_q, dir_d;
  logic               ph_q, ph_d;
  led_mode_t          mode_q;
  logic [LED_NUM-1:0] led_q, led_d;
  logic               step_q;
  logic               restart;
  logic               tick;
  logic               adv;

  assign restart = (bus.mode != mode_q);
  assign adv     = tick && !restart;

  step_tick_gen #(
    .STEP_CYCLES (STEP_CYCLES)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (!bus.pause),
    .clr   (restart),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q  <= POS_MAX;
      dir_q  <= 1'b0;
      ph_q   <= 1'b0;
      mode_q <= LED_MODE_ROR;
      led_q  <= LED_RST;
      step_q <= 1'b0;
    end else begin
      pos_q  <= pos_d;
      dir_q  <= dir_d;
      ph_q   <= ph_d;
      mode_q <= bus.mode;
      led_q  <= led_d;
      step_q <= adv;
    end
  end

  // Restart takes priority over an advance landing in the same cycle.
  always_comb begin
    pos_d = pos_q;
    dir_d = dir_q;
    ph_d  = ph_q;
    if (restart) begin
      case (bus.mode)
        LED_MODE_ROR: pos_d = POS_MAX;
        LED_MODE_ROL: pos_d = '0;
        LED_MODE_PINGPONG: begin
          pos_d = POS_MAX;
          dir_d = 1'b0;
        end
        default: ph_d = 1'b0;
      endcase
    end else if (adv) begin
      case (bus.mode)
        LED_MODE_ROR: pos_d = (pos_q == '0) ? POS_MAX : pos_q - PW'(1);
        LED_MODE_ROL: pos_d = (pos_q == POS_MAX) ? '0 : pos_q + PW'(1);
        LED_MODE_PINGPONG: begin
          // Flip on arrival so the end LED is shown for exactly one step.
          if (dir_q) begin
            pos_d = pos_q + PW'(1);
            if (pos_d == POS_MAX) dir_d = 1'b0;
          end else begin
            pos_d = pos_q - PW'(1);
            if (pos_d == '0) dir_d = 1'b1;
          end
        end
        default: ph_d = ~ph_q;
      endcase
    end
  end

  // Decode from next state so led lines up with step in the same cycle.
  always_comb begin
    led_d = '1;
    if (bus.mode == LED_MODE_BLINK) begin
      led_d = {LED_NUM{ph_d}};
    end else begin
      led_d[pos_d] = 1'b0;
    end
  end

  assign bus.led  = led_q;
  assign bus.step = step_q;

endmodule

// File: tb/tb_led_flow_ctrl.sv
// Directed bench for led_flow_ctrl with N=4, STEP_CYCLES=4; expected LED words are queued and popped on each step.
module tb_led_flow_ctrl;
  import led_pkg::*;

  localparam int N  = 4;
  localparam int SC = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  logic [N-1:0] exp_q[$];

  logic [N-1:0] seq_ror [4] = '{4'b1011, 4'b1101, 4'b1110, 4'b0111};
  logic [N-1:0] seq_rol [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
  logic [N-1:0] seq_pp  [7] = '{4'b1011, 4'b1101, 4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1011};
  logic [N-1:0] seq_bl  [3] = '{4'b1111, 4'b0000, 4'b1111};

  led_flow_ctrl_if #(.LED_NUM(N)) bus ();

  led_flow_ctrl #(
    .LED_NUM     (N),
    .STEP_CYCLES (SC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits for the next step pulse, checks its distance, that led held until then, and its value.
  task automatic wait_step(input string tag, input int gap);
    int           n;
    logic [N-1:0] held;
    logic         held_ok;
    logic [N-1:0] exp;
    n       = 0;
    held    = bus.led;
    held_ok = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (!bus.step && bus.led !== held) held_ok = 1'b0;
    end while (!bus.step && n < gap + 8);
    chk({tag, ".gap"}, n, gap);
    chk({tag, ".hold"}, {31'd0, held_ok}, 32'd1);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    chk({tag, ".led"}, {28'd0, bus.led}, {28'd0, exp});
  endtask

  task automatic set_mode(input led_mode_t m, input logic [N-1:0] start, input string tag);
    bus.mode = m;
    @(negedge clk);
    chk({tag, ".led"}, {28'd0, bus.led}, {28'd0, start});
    chk({tag, ".step"}, {31'd0, bus.step}, 32'd0);
  endtask

  task automatic frozen(input int n, input string tag);
    logic [N-1:0] held;
    logic         step_seen;
    logic         moved;
    held      = bus.led;
    step_seen = 1'b0;
    moved     = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (bus.step !== 1'b0) step_seen = 1'b1;
      if (bus.led !== held) moved = 1'b1;
    end
    chk({tag, ".nostep"}, {31'd0, step_seen}, 32'd0);
    chk({tag, ".nomove"}, {31'd0, moved}, 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.mode  = LED_MODE_ROR;
    bus.pause = 1'b0;
    cyc(2);
    chk("rst.led", {28'd0, bus.led}, 32'h7);
    chk("rst.step", {31'd0, bus.step}, 32'd0);
    rst_n = 1'b1;

    foreach (seq_ror[i]) exp_q.push_back(seq_ror[i]);
    for (int i = 0; i < 4; i++) wait_step("ror", SC);

    set_mode(LED_MODE_ROL, 4'b1110, "to_rol");
    foreach (seq_rol[i]) exp_q.push_back(seq_rol[i]);
    for (int i = 0; i < 4; i++) wait_step("rol", SC);

    set_mode(LED_MODE_PINGPONG, 4'b0111, "to_pp");
    foreach (seq_pp[i]) exp_q.push_back(seq_pp[i]);
    for (int i = 0; i < 7; i++) wait_step("pp", SC);

    set_mode(LED_MODE_BLINK, 4'b0000, "to_blink");
    foreach (seq_bl[i]) exp_q.push_back(seq_bl[i]);
    for (int i = 0; i < 3; i++) wait_step("blink", SC);

    // Pause with the divider at 2: two more clocks remain after release.
    cyc(2);
    bus.pause = 1'b1;
    frozen(10, "pause");
    bus.pause = 1'b0;
    exp_q.push_back(4'b0000);
    wait_step("unpause", 2);

    // Mode change in the tick cycle must suppress the step.
    set_mode(LED_MODE_ROR, 4'b0111, "to_ror2");
    cyc(3);
    set_mode(LED_MODE_PINGPONG, 4'b0111, "restart_on_tick");
    exp_q.push_back(4'b1011);
    wait_step("after_restart", SC);

    bus.pause = 1'b1;
    set_mode(LED_MODE_ROL, 4'b1110, "paused_restart");
    frozen(6, "paused_hold");
    bus.pause = 1'b0;
    exp_q.push_back(4'b1101);
    wait_step("resume", SC);

    // Bring ping-pong onto its upward leg, then reset mid-period.
    set_mode(LED_MODE_PINGPONG, 4'b0111, "to_pp2");
    exp_q.push_back(4'b1011);
    exp_q.push_back(4'b1101);
    exp_q.push_back(4'b1110);
    exp_q.push_back(4'b1101);
    for (int i = 0; i < 4; i++) wait_step("pp2", SC);
    cyc(1);
    rst_n = 1'b0;
    #1;
    chk("midrst.led", {28'd0, bus.led}, 32'h7);
    chk("midrst.step", {31'd0, bus.step}, 32'd0);
    cyc(2);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst.led", {28'd0, bus.led}, 32'h7);
    chk("postrst.step", {31'd0, bus.step}, 32'd0);
    exp_q.push_back(4'b1011);
    exp_q.push_back(4'b1101);
    for (int i = 0; i < 2; i++) wait_step("postrst_pp", SC);

    chk("sb.empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_flow_ctrl.md
# led_flow_ctrl

Parametrised LED pattern generator that drives `LED_NUM` active-low LEDs from the system clock, advancing one step every `STEP_CYCLES` clocks. It supports four runtime-selectable modes: rotate right, rotate left, ping-pong and all-blink. It also provides pause and restart-on-mode-change. It sits directly behind the board LED pins and replaces the fixed 4-LED, 1 Hz-clocked flow block; its internal step divider removes the need for a separate 1 Hz clock.

## Interface
Parameters:
- `LED_NUM`, 4: number of LEDs; legal range ≥ 2.
- `STEP_CYCLES`, 50_000_000: clocks per pattern step (1 s at 50 MHz); legal range ≥ 2.

Ports:
- `clk`  input  1  system clock. One clock domain only.
- `rst_n`  input  1  asynchronous, active-low reset.
- `mode`  input  2  pattern select. 0 = rotate right, 1 = rotate left, 2 = ping-pong, 3 = all-blink. Synchronous to `clk`.
- `pause`  input  1  high freezes the step counter and the pattern.
- `led`  output  `LED_NUM`  LED drive, active low (0 = lit). Registered.
- `step`  output  1  one-cycle pulse on each pattern advance. Registered.

## Operation
- Internal state:
  - step counter `cnt`, width `$clog2(STEP_CYCLES)`;
  - lit position `pos`, width `$clog2(LED_NUM)`;
  - direction `dir` (0 = down, 1 = up);
  - blink phase `ph` (0 = all lit, 1 = all dark);
  - registered `mode_q`.
- Tick: asserted when `cnt == STEP_CYCLES-1` and `pause == 0`.
  - On tick, `cnt` wraps to 0; otherwise it increments while unpaused and holds while paused.
- Restart: asserted when `mode != mode_q`. Restart loads the start state for the new mode, clears `cnt` to 0 and issues no `step` pulse. Restart overrides tick in the same cycle. Restart also applies while paused; the pattern then stays frozen at the start state.
- Start states:
  - rotate right: `pos = LED_NUM-1`;
  - rotate left: `pos = 0`;
  - ping-pong: `pos = LED_NUM-1`, `dir = 0`;
  - all-blink: `ph = 0`.
- Per-tick advance:
  - Rotate right: `pos` decrements, wrapping from 0 to `LED_NUM-1`. With `LED_NUM = 4`, `led` cycles 0111 → 1011 → 1101 → 1110 → 0111.
  - Rotate left: `pos` increments, wrapping from `LED_NUM-1` to 0.
  - Ping-pong: `pos` moves one place in direction `dir`. At an end, `dir` flips in the same tick that reaches the end, so end LEDs are not repeated. For N = 4 the sequence is 3,2,1,0,1,2,3,2,… with period 2·(N−1) steps.
  - All-blink: `ph` toggles.
- Output decode:
  - modes 0–2: `led` = all ones except bit `pos` = 0;
  - mode 3: `led` = `{LED_NUM{ph}}`.
- Reset: `cnt = 0`, `pos = LED_NUM-1`, `dir = 0`, `ph = 0`, `mode_q = 0`, `led` = MSB lit (4'b0111 for N = 4), `step = 0`.
  - The first restart after reset occurs only if `mode` ≠ 0 at the first clock. Reset mid-pattern returns to this state immediately.

## Timing
- `led` and `step` are both registered.
- A tick in cycle t produces the updated `led` and `step = 1` in cycle t+1.
- First update after reset release (mode 0, unpaused): `led` changes STEP_CYCLES clocks after the first rising edge with `rst_n` high.
- Restart in cycle t gives the start-state `led` in cycle t+1. The next advance follows STEP_CYCLES clocks later.
- Pause asserted in cycle t: the tick is suppressed in t if `cnt` was terminal, and `cnt` holds from t. On deassertion, counting resumes from the held value with no lost or extra steps.
- `step` is never high for two consecutive cycles, since STEP_CYCLES ≥ 2.

## Structure
- Shared package `led_pkg`:
  - mode constants `LED_MODE_ROR = 2'd0`, `LED_MODE_ROL = 2'd1`, `LED_MODE_PINGPONG = 2'd2`, `LED_MODE_BLINK = 2'd3`;
  - the default `STEP_CYCLES` for 50 MHz.
- One sub-module, `step_tick_gen` (parameter `STEP_CYCLES`; ports `clk`, `rst_n`, `en`, `clr`, `tick`), holds `cnt`.
  - `en` = not paused; `clr` = restart.
- Pattern state, direction logic and output decode live in `led_flow_ctrl`.

## Test plan
All scenarios use `LED_NUM = 4`, `STEP_CYCLES = 4`.
- Reset then mode 0: `led` = 0111 after reset; then 1011, 1101, 1110, 0111 at 4-clock intervals, each change coincident with `step = 1`.
- Mode 1 and mode 2:
  - mode 1 → 1110, 1101, 1011, 0111, 1110;
  - mode 2 → 0111, 1011, 1101, 1110, 1101, 1011, 0111, 1011. No end LED repeats.
- Mode 3 → `led` = 0000, 1111, 0000 alternating every 4 clocks.
- Pause at `cnt = 2` for 10 clocks: `led` and `step` are frozen. After release, the next step arrives exactly 2 clocks later.
- Mode change from 0 to 2 in the same cycle as a tick: no `step` pulse, `led` = 0111 next cycle, next advance (1011) 4 clocks later. A mode change while paused gives the start state and stays frozen.
- Assert `rst_n` low mid-pattern in mode 2 with `dir` up: `led` = 0111 and `step = 0` immediately. After release, counting restarts from `cnt = 0` in the mode currently on the input.
